// File: rtl/bus_if_pkg.sv
// Shared definitions for the CPU-side bus master interface: state encodings,
// timeout counter width and the bus polarity constants.
package bus_if_pkg;

    localparam int BUS_IF_STATE_W   = 2;
    localparam int BUS_IF_TIMEOUT_W = 8;

    typedef logic [BUS_IF_STATE_W-1:0] BusIfStateBus;

    typedef enum BusIfStateBus {
        BUS_IF_STATE_IDLE   = 2'd0,
        BUS_IF_STATE_REQ    = 2'd1,
        BUS_IF_STATE_ACCESS = 2'd2,
        BUS_IF_STATE_STALL  = 2'd3
    } BusIfState;

    localparam logic ENABLE_      = 1'b0;
    localparam logic DISABLE_     = 1'b1;
    localparam logic READ         = 1'b1;
    localparam logic WRITE        = 1'b0;
    localparam logic RESET_ENABLE = 1'b0;

endpackage

// File: rtl/bus_if.sv
// Bus master interface: turns a pipeline memory request into a request/grant,
// one-cycle address strobe and ready handshake, with a timeout abort.
module bus_if
    import bus_if_pkg::*;
#(
    parameter int ADDR_W  = 30,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              stall,
    input  logic              flush,
    input  logic              as_,
    input  logic              rw,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic [DATA_W-1:0] rd_data,
    output logic              busy,
    output logic              err,
    output logic              bus_req_,
    input  logic              bus_grnt_,
    output logic              bus_as_,
    output logic              bus_rw,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [DATA_W-1:0] bus_wr_data,
    input  logic [DATA_W-1:0] bus_rd_data,
    input  logic              bus_rdy_
);

    localparam logic [BUS_IF_TIMEOUT_W-1:0] TIMEOUT_CNT = BUS_IF_TIMEOUT_W'(TIMEOUT);

    BusIfState                   state_q, state_d;
    logic                        busReq_q, busReq_d;
    logic                        busAs_q, busAs_d;
    logic                        busRw_q, busRw_d;
    logic [ADDR_W-1:0]           busAddr_q, busAddr_d;
    logic [DATA_W-1:0]           busWrData_q, busWrData_d;
    logic [DATA_W-1:0]           rdBuf_q, rdBuf_d;
    logic [BUS_IF_TIMEOUT_W-1:0] count_q, count_d;

    // Next-state and handshake decode; busy/err/rd_data are combinational so the
    // pipeline can advance in the very cycle the slave answers.
    always_comb begin
        state_d     = state_q;
        busReq_d    = busReq_q;
        busAs_d     = busAs_q;
        busRw_d     = busRw_q;
        busAddr_d   = busAddr_q;
        busWrData_d = busWrData_q;
        rdBuf_d     = rdBuf_q;
        count_d     = count_q;
        busy        = 1'b0;
        err         = 1'b0;
        rd_data     = '0;

        unique case (state_q)
            BUS_IF_STATE_IDLE: begin
                if (as_ == ENABLE_ && !flush) begin
                    busy        = 1'b1;
                    busReq_d    = ENABLE_;
                    busRw_d     = rw;
                    busAddr_d   = addr;
                    busWrData_d = wr_data;
                    state_d     = BUS_IF_STATE_REQ;
                end
            end
            BUS_IF_STATE_REQ: begin
                busy = 1'b1;
                if (bus_grnt_ == ENABLE_) begin
                    busAs_d = ENABLE_;
                    count_d = '0;
                    state_d = BUS_IF_STATE_ACCESS;
                end
            end
            BUS_IF_STATE_ACCESS: begin
                busAs_d = DISABLE_;
                // Ready is tested before the timeout so a late answer still completes.
                if (bus_rdy_ == ENABLE_) begin
                    rd_data  = bus_rd_data;
                    rdBuf_d  = bus_rd_data;
                    busReq_d = DISABLE_;
                    state_d  = stall ? BUS_IF_STATE_STALL : BUS_IF_STATE_IDLE;
                end else if (count_q == TIMEOUT_CNT) begin
                    err      = 1'b1;
                    rdBuf_d  = '0;
                    busReq_d = DISABLE_;
                    state_d  = stall ? BUS_IF_STATE_STALL : BUS_IF_STATE_IDLE;
                end else begin
                    busy    = 1'b1;
                    count_d = count_q + 1'b1;
                end
            end
            BUS_IF_STATE_STALL: begin
                rd_data = rdBuf_q;
                if (!stall) begin
                    state_d = BUS_IF_STATE_IDLE;
                end
            end
            default: begin
                state_d = BUS_IF_STATE_IDLE;
            end
        endcase

        if (reset == RESET_ENABLE) begin
            busy    = 1'b0;
            err     = 1'b0;
            rd_data = '0;
        end
    end

    // State and bus registers; reset releases the bus immediately.
    always_ff @(posedge clk) begin
        if (reset == RESET_ENABLE) begin
            state_q     <= BUS_IF_STATE_IDLE;
            busReq_q    <= DISABLE_;
            busAs_q     <= DISABLE_;
            busRw_q     <= READ;
            busAddr_q   <= '0;
            busWrData_q <= '0;
            rdBuf_q     <= '0;
            count_q     <= '0;
        end else begin
            state_q     <= state_d;
            busReq_q    <= busReq_d;
            busAs_q     <= busAs_d;
            busRw_q     <= busRw_d;
            busAddr_q   <= busAddr_d;
            busWrData_q <= busWrData_d;
            rdBuf_q     <= rdBuf_d;
            count_q     <= count_d;
        end
    end

    assign bus_req_    = busReq_q;
    assign bus_as_     = busAs_q;
    assign bus_rw      = busRw_q;
    assign bus_addr    = busAddr_q;
    assign bus_wr_data = busWrData_q;

endmodule
